// File: rtl/fm_wb_master_arb_pkg.sv
// Shared types and helpers for the fm native-to-Wishbone master arbiter.
// Optional watchdog macro: FM_WB_TIMEOUT_EN.
package fm_wb_master_arb_pkg;

    // Uncomment to build the bus-timeout watchdog in by default:
    // `define FM_WB_TIMEOUT_EN

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_e;

    function automatic int fm_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fm_wb_master_arb_if.sv
// Bundle of native fm master ports and the Wishbone master bus.
// master = arbiter side, slave = clients plus fabric side.
interface fm_wb_master_arb_if
    import fm_wb_master_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 3
);
    logic [NUM_CH-1:0]               i_req_m;
    logic [NUM_CH-1:0]               i_wr_m;
    logic [NUM_CH*ADDR_W-1:0]        i_adrs_m;
    logic [NUM_CH*LEN_W-1:0]         i_len_m;
    logic [NUM_CH*DATA_W/BYTE_W-1:0] i_be_m;
    logic [NUM_CH*DATA_W-1:0]        i_dbw_m;
    logic [NUM_CH-1:0]               o_ack_m;
    logic [NUM_CH-1:0]               o_wack_m;
    logic [NUM_CH-1:0]               o_strr_m;
    logic [DATA_W-1:0]               o_dbr_m;
    logic                            o_busy;
    logic                            o_err;
    logic                            m_wb_cyc_o;
    logic                            m_wb_stb_o;
    logic                            m_wb_we_o;
    logic [ADDR_W-1:0]               m_wb_adr_o;
    logic [DATA_W/BYTE_W-1:0]        m_wb_sel_o;
    logic [DATA_W-1:0]               m_wb_dat_o;
    logic [DATA_W-1:0]               m_wb_dat_i;
    logic                            m_wb_ack_i;

    modport master (
        input  i_req_m, i_wr_m, i_adrs_m, i_len_m, i_be_m, i_dbw_m,
        input  m_wb_dat_i, m_wb_ack_i,
        output o_ack_m, o_wack_m, o_strr_m, o_dbr_m, o_busy, o_err,
        output m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o,
        output m_wb_sel_o, m_wb_dat_o
    );

    modport slave (
        output i_req_m, i_wr_m, i_adrs_m, i_len_m, i_be_m, i_dbw_m,
        output m_wb_dat_i, m_wb_ack_i,
        input  o_ack_m, o_wack_m, o_strr_m, o_dbr_m, o_busy, o_err,
        input  m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_adr_o,
        input  m_wb_sel_o, m_wb_dat_o
    );

endinterface

// File: rtl/fm_wb_master_arb_rr.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
// The pointer register is owned by the parent.
module fm_rr_arb
    import fm_wb_master_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = fm_clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              gnt_vld_o
);
    int               c;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        c         = 0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = int'(ptr_i) + i;
            if (c >= NUM_CH) c = c - NUM_CH;
            idx = IDX_W'(c);
            if (en_i && !gnt_vld_o && req_i[idx]) begin
                gnt_vld_o      = 1'b1;
                gnt_oh_o[idx]  = 1'b1;
                gnt_idx_o      = idx;
            end
        end
    end

endmodule

// File: rtl/fm_wb_master_arb.sv
// NUM_CH fm native masters round-robin arbitrated onto one Wishbone burst master.
// Define FM_WB_TIMEOUT_EN to build in the stalled-bus watchdog.
module fm_wb_master_arb
    import fm_wb_master_arb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                clk_i,
    input logic                rst_ni,
    fm_wb_master_arb_if.master bus
);
    localparam int BE_W  = DATA_W / BYTE_W;
    localparam int IDX_W = fm_clog2(NUM_CH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d, g_q, g_d;
    logic              wr_q, wr_d, cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] dbr_q, dbr_d;
    logic [NUM_CH-1:0] strr_q, strr_d;

    logic [NUM_CH-1:0] gnt_oh, g_oh;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld, arb_en, wb_ack, last, to_hit;

    assign arb_en = rst_ni && (state_q == IDLE);
    assign g_oh   = NUM_CH'(1) << g_q;
    assign wb_ack = bus.m_wb_ack_i && cyc_q && (state_q == XFER);
    assign last   = (cnt_q == len_q);

    fm_rr_arb #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .req_i    (bus.i_req_m),
        .ptr_i    (ptr_q),
        .en_i     (arb_en),
        .gnt_oh_o (gnt_oh),
        .gnt_idx_o(gnt_idx),
        .gnt_vld_o(gnt_vld)
    );

`ifdef FM_WB_TIMEOUT_EN
    localparam int TO_W = fm_clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;

    // Counts consecutive ack-less XFER cycles; any ack or a new burst clears it.
    assign to_hit = (state_q == XFER) && !wb_ack &&
                    (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign err_d  = to_hit;

    always_comb begin
        to_d = to_q;
        if (state_q == IDLE || wb_ack) to_d = '0;
        else if (state_q == XFER)      to_d = to_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign bus.o_err = err_q;
`else
    assign to_hit    = 1'b0;
    assign bus.o_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        wr_d    = wr_q;
        adr_d   = adr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        cyc_d   = cyc_q;
        dbr_d   = dbr_q;
        strr_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    g_d     = gnt_idx;
                    wr_d    = bus.i_wr_m[gnt_idx];
                    adr_d   = bus.i_adrs_m[gnt_idx*ADDR_W +: ADDR_W];
                    len_d   = bus.i_len_m[gnt_idx*LEN_W +: LEN_W];
                    be_d    = bus.i_be_m[gnt_idx*BE_W +: BE_W];
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    state_d = XFER;
                    ptr_d   = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
            XFER: begin
                if (wb_ack) begin
                    adr_d = adr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (!wr_q) begin
                        dbr_d  = bus.m_wb_dat_i;
                        strr_d = g_oh;
                    end
                    if (last) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (to_hit) begin
                    cyc_d   = 1'b0;
                    state_d = wr_q ? IDLE : ABORT;
                end
            end
            ABORT: begin
                // Flush the unread beats with zero data so the client unblocks.
                strr_d = g_oh;
                dbr_d  = '0;
                cnt_d  = cnt_q + 1'b1;
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            cyc_q   <= 1'b0;
            dbr_q   <= '0;
            strr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            wr_q    <= wr_d;
            adr_q   <= adr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            be_q    <= be_d;
            cyc_q   <= cyc_d;
            dbr_q   <= dbr_d;
            strr_q  <= strr_d;
        end
    end

    assign bus.o_ack_m    = gnt_oh;
    assign bus.o_wack_m   = (wb_ack && wr_q) ? g_oh : '0;
    assign bus.o_strr_m   = strr_q;
    assign bus.o_dbr_m    = dbr_q;
    assign bus.o_busy     = (state_q != IDLE);
    assign bus.m_wb_cyc_o = cyc_q;
    assign bus.m_wb_stb_o = cyc_q;
    assign bus.m_wb_we_o  = cyc_q && wr_q;
    assign bus.m_wb_adr_o = adr_q;
    assign bus.m_wb_sel_o = cyc_q ? be_q : '0;
    assign bus.m_wb_dat_o = (cyc_q && wr_q) ? bus.i_dbw_m[g_q*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_fm_wb_master_arb.sv
// Directed bench for fm_wb_master_arb: burst table, round-robin order,
// stall, mid-burst reset and (with FM_WB_TIMEOUT_EN) the watchdog abort.
module tb_fm_wb_master_arb;
    localparam int N  = 4;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int LW = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fm_wb_master_arb_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    fm_wb_master_arb #(
        .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          ch;
        bit          wr;
        logic [AW-1:0] adrs;
        int          len;
        logic [3:0]  be;
        int          stall_beat;
        int          stall_len;
        logic [DW-1:0] data;
        logic [AW-1:0] last_adr;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic burst(input vec_t v);
        int            beat, stall, wacks, strrs, cyc;
        logic          prev_rd, ack_now;
        logic [DW-1:0] prev_dat, cur_dat;
        logic [AW-1:0] exp_adr, seen_last;
        beat = 0; stall = 0; wacks = 0; strrs = 0;
        prev_rd = 1'b0; prev_dat = '0; seen_last = '0;
        bus.i_req_m                    = '0;
        bus.i_req_m[v.ch]              = 1'b1;
        bus.i_wr_m[v.ch]               = v.wr;
        bus.i_adrs_m[v.ch*AW +: AW]    = v.adrs;
        bus.i_len_m[v.ch*LW +: LW]     = LW'(v.len);
        bus.i_be_m[v.ch*4 +: 4]        = v.be;
        bus.i_dbw_m[v.ch*DW +: DW]     = v.data;
        bus.m_wb_ack_i                 = 1'b0;
        smp();
        chk("cmd_ack", bus.o_ack_m, 1 << v.ch);
        step();
        bus.i_req_m = '0;
        for (cyc = 0; cyc < 60 && (beat <= v.len || prev_rd); cyc++) begin
            ack_now = (beat <= v.len) && !(beat == v.stall_beat && stall < v.stall_len);
            cur_dat = v.data + DW'(beat);
            exp_adr = v.adrs + AW'(beat);
            bus.m_wb_ack_i = ack_now;
            bus.m_wb_dat_i = cur_dat;
            smp();
            chk("strr", bus.o_strr_m, prev_rd ? (1 << v.ch) : 0);
            if (prev_rd) begin
                chk("dbr", bus.o_dbr_m, prev_dat);
                strrs++;
            end
            if (beat <= v.len) begin
                chk("cyc_stb_we", {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.m_wb_we_o},
                    {1'b1, 1'b1, v.wr});
                chk("adr", bus.m_wb_adr_o, exp_adr);
                chk("sel", bus.m_wb_sel_o, v.be);
                if (v.wr) chk("dat_o", bus.m_wb_dat_o, cur_dat);
                chk("wack", bus.o_wack_m, (ack_now && v.wr) ? (1 << v.ch) : 0);
            end else begin
                chk("cyc_end", {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.o_busy}, 0);
            end
            prev_rd  = ack_now && !v.wr;
            prev_dat = cur_dat;
            if (ack_now) begin
                if (beat == v.len) seen_last = bus.m_wb_adr_o;
                if (v.wr) wacks++;
                beat++;
            end else if (beat == v.stall_beat) begin
                stall++;
            end
            step();
            if (v.wr) bus.i_dbw_m[v.ch*DW +: DW] = v.data + DW'(beat);
        end
        bus.m_wb_ack_i = 1'b0;
        chk("beats", beat, v.len + 1);
        chk("last_adr", seen_last, v.last_adr);
        chk("pulses", v.wr ? wacks : strrs, v.len + 1);
        smp();
        chk("idle", {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.o_busy, bus.o_strr_m}, 0);
        step();
    endtask

    logic [N-1:0] got[6];
    logic [N-1:0] exp_rr[6];
    logic [N-1:0] prev_ack;
    int           gcount;

    initial begin
        vecs[0] = '{0, 1'b0, 30'h100,      0, 4'hF, 0, 2,  32'hDEADBEEF, 30'h100};
        vecs[1] = '{2, 1'b1, 30'h3FFFFFFC, 7, 4'hF, 8, 0,  32'h10000000, 30'h3};
        vecs[2] = '{1, 1'b1, 30'h2000,     3, 4'h3, 2, 10, 32'hA5A50000, 30'h2003};
        vecs[3] = '{3, 1'b0, 30'h55,       2, 4'h9, 1, 3,  32'h77000000, 30'h57};
        exp_rr  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

        bus.i_req_m = '1; bus.i_wr_m = '0; bus.i_adrs_m = '0; bus.i_len_m = '0;
        bus.i_be_m = '0; bus.i_dbw_m = '0; bus.m_wb_dat_i = '0; bus.m_wb_ack_i = 1'b0;

        step(); step();
        smp();
        chk("rst_ctl", {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.m_wb_we_o, bus.o_busy,
                        bus.o_err, bus.o_ack_m, bus.o_wack_m, bus.o_strr_m}, 0);
        chk("rst_adr_sel", {bus.m_wb_adr_o, bus.m_wb_sel_o}, 0);
        chk("rst_dbr", bus.o_dbr_m, 0);
        step();
        rst_n = 1'b1;
        bus.i_req_m = '0;

        // Round-robin: everyone requests, each drops for one cycle after its ack.
        bus.m_wb_ack_i = 1'b1;
        prev_ack = '0;
        gcount = 0;
        for (int c = 0; c < 40 && gcount < 6; c++) begin
            bus.i_req_m = '1 & ~prev_ack;
            smp();
            if (|bus.o_ack_m) begin
                got[gcount] = bus.o_ack_m;
                gcount++;
            end
            prev_ack = bus.o_ack_m;
            step();
        end
        bus.i_req_m = '0;
        step(); step();
        bus.m_wb_ack_i = 1'b0;
        chk("rr_count", gcount, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_grant%0d", k), got[k], exp_rr[k]);
        smp();
        chk("rr_idle", bus.o_busy, 0);
        step();

        for (int i = 0; i < 4; i++) burst(vecs[i]);

        // Reset during beat 3 of an 8-beat write; pointer must restart at ch0.
        bus.i_req_m = 4'b0100; bus.i_wr_m = 4'b0100; bus.i_len_m = '0;
        bus.i_len_m[2*LW +: LW] = 3'd7;
        bus.i_adrs_m[2*AW +: AW] = 30'h40;
        smp();
        chk("rstb_ack", bus.o_ack_m, 4'b0100);
        step();
        bus.i_req_m = '0;
        bus.m_wb_ack_i = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.m_wb_ack_i = 1'b0;
        smp();
        chk("rstb_ctl", {bus.m_wb_cyc_o, bus.m_wb_stb_o, bus.m_wb_we_o, bus.o_busy,
                         bus.o_err, bus.o_ack_m, bus.o_wack_m, bus.o_strr_m}, 0);
        chk("rstb_adr_sel", {bus.m_wb_adr_o, bus.m_wb_sel_o}, 0);
        chk("rstb_dat", {bus.m_wb_dat_o, bus.o_dbr_m}, 0);
        step();
        bus.i_wr_m = '0; bus.i_len_m = '0;
        bus.i_req_m = '1;
        smp();
        chk("rstb_ptr", bus.o_ack_m, 4'b0001);
        step();
        bus.i_req_m = '0;
        bus.m_wb_ack_i = 1'b1;
        step();
        bus.m_wb_ack_i = 1'b0;
        smp();
        chk("rstb_idle", bus.o_busy, 0);
        step();

`ifdef FM_WB_TIMEOUT_EN
        begin
            int n, pulses;
            bus.i_req_m = 4'b0010; bus.i_wr_m = '0;
            bus.i_len_m[1*LW +: LW] = 3'd3;
            smp();
            chk("to_ack", bus.o_ack_m, 4'b0010);
            step();
            bus.i_req_m = '0;
            n = 0;
            for (int c = 0; c < 40; c++) begin
                smp();
                if (bus.o_err) break;
                n++;
                step();
            end
            chk("to_stall_cycles", n, 16);
            chk("to_cyc_low", bus.m_wb_cyc_o, 0);
            pulses = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                smp();
                if (bus.o_strr_m == 4'b0010) begin
                    pulses++;
                    chk("to_dbr", bus.o_dbr_m, 0);
                end
            end
            chk("to_pulses", pulses, 4);
            chk("to_idle", bus.o_busy, 0);
            step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
